// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes,
// FSM state encodings and a constant-evaluable clog2.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte over the old one.
module axi4_lite_strb_merge
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with a per-register read-only mask backed by
// HW_STATUS; read and write paths run as independent two-state FSMs.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                   ADDRESS    = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   REG_COUNT  = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [ADDRESS-1:0]              S_ARADDR,
  input  logic                            S_ARVALID,
  output logic                            S_ARREADY,
  output logic [DATA_WIDTH-1:0]           S_RDATA,
  output logic [1:0]                      S_RRESP,
  output logic                            S_RVALID,
  input  logic                            S_RREADY,
  input  logic [ADDRESS-1:0]              S_AWADDR,
  input  logic                            S_AWVALID,
  output logic                            S_AWREADY,
  input  logic [DATA_WIDTH-1:0]           S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]         S_WSTRB,
  input  logic                            S_WVALID,
  output logic                            S_WREADY,
  output logic [1:0]                      S_BRESP,
  output logic                            S_BVALID,
  input  logic                            S_BREADY,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] HW_STATUS,
  output logic [REG_COUNT*DATA_WIDTH-1:0] REG_OUT,
  output logic [REG_COUNT-1:0]            WR_PULSE
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_BITS = clog2(REG_COUNT);
  localparam int IDX_W    = (IDX_BITS == 0) ? 1 : IDX_BITS;
  localparam int KEEP_W   = ADDR_LSB + IDX_W;

  // Only the byte offset and index bits matter; the rest of the address is ignored.
  function automatic logic [IDX_W-1:0] addr_index(input logic [KEEP_W-1:0] a);
    if (IDX_BITS == 0) return '0;
    return a[ADDR_LSB +: IDX_W];
  endfunction

  function automatic logic addr_err(input logic [KEEP_W-1:0] a);
    return (a[ADDR_LSB-1:0] != '0) || (int'(addr_index(a)) >= REG_COUNT);
  endfunction

  wstate_e                wstate_q, wstate_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic [KEEP_W-1:0]      awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [REG_COUNT-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]  regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0]  regs_d [REG_COUNT];

  rstate_e                rstate_q, rstate_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  logic [IDX_W-1:0]       w_idx, r_idx;
  logic                   w_err, r_err;
  logic [KEEP_W-1:0]      araddr;
  logic [DATA_WIDTH-1:0]  merged;
  logic                   unused_addr;

  assign unused_addr = ^{S_AWADDR[ADDRESS-1:KEEP_W], S_ARADDR[ADDRESS-1:KEEP_W]};

  assign w_idx  = addr_index(awaddr_q);
  assign w_err  = addr_err(awaddr_q) || RO_MASK[w_idx] || (wstrb_q == '0);
  assign araddr = S_ARADDR[KEEP_W-1:0];
  assign r_idx  = addr_index(araddr);
  assign r_err  = addr_err(araddr);

  axi4_lite_strb_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_merge (
    .old_data(regs_q[w_idx]),
    .new_data(wdata_q),
    .strb    (wstrb_q),
    .merged  (merged)
  );

  assign S_AWREADY = (wstate_q == W_IDLE) && !aw_held_q;
  assign S_WREADY  = (wstate_q == W_IDLE) && !w_held_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign WR_PULSE  = wr_pulse_q;
  assign S_ARREADY = (rstate_q == R_IDLE);
  assign S_RVALID  = rvalid_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

  always_comb begin
    REG_OUT = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      REG_OUT[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  // Commit happens one edge after the later of AW/W is captured into the holding regs.
  always_comb begin
    wstate_d   = wstate_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          bvalid_d = 1'b1;
          bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
          wstate_d = W_RESP;
          if (!w_err) begin
            regs_d[w_idx]     = merged;
            wr_pulse_d[w_idx] = 1'b1;
          end
        end else begin
          if (S_AWVALID && !aw_held_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AWADDR[KEEP_W-1:0];
          end
          if (S_WVALID && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = S_WDATA;
            wstrb_d  = S_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (S_ARVALID) begin
          rvalid_d = 1'b1;
          rstate_d = R_DATA;
          if (r_err) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d = RESP_OKAY;
            rdata_d = RO_MASK[r_idx] ? HW_STATUS[r_idx*DATA_WIDTH +: DATA_WIDTH]
                                     : regs_q[r_idx];
          end
        end
      end
      R_DATA: begin
        if (S_RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q   <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      rstate_q   <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wstate_q   <= wstate_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rstate_q   <= rstate_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Self-checking bench for axi4_lite_regbank: a behavioural register model
// feeds B/R expectation queues that are popped as the DUT responds.
module tb_axi4_lite_regbank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NREG = 12;
  localparam logic [NREG-1:0] RO = 12'h008;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  logic                 ACLK = 1'b0;
  logic                 ARESETN = 1'b0;
  logic [AW-1:0]        S_ARADDR = '0;
  logic                 S_ARVALID = 1'b0;
  logic                 S_ARREADY;
  logic [DW-1:0]        S_RDATA;
  logic [1:0]           S_RRESP;
  logic                 S_RVALID;
  logic                 S_RREADY = 1'b0;
  logic [AW-1:0]        S_AWADDR = '0;
  logic                 S_AWVALID = 1'b0;
  logic                 S_AWREADY;
  logic [DW-1:0]        S_WDATA = '0;
  logic [DW/8-1:0]      S_WSTRB = '0;
  logic                 S_WVALID = 1'b0;
  logic                 S_WREADY;
  logic [1:0]           S_BRESP;
  logic                 S_BVALID;
  logic                 S_BREADY = 1'b0;
  logic [NREG*DW-1:0]   HW_STATUS;
  logic [NREG*DW-1:0]   REG_OUT;
  logic [NREG-1:0]      WR_PULSE;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [DW-1:0] model_regs [NREG];
  logic [1:0]    exp_b[$];
  logic [NREG-1:0] exp_pulse[$];
  rexp_t         exp_r[$];

  axi4_lite_regbank #(
    .ADDRESS(AW), .DATA_WIDTH(DW), .REG_COUNT(NREG), .RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .HW_STATUS(HW_STATUS), .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    for (int i = 0; i < NREG; i++) begin
      HW_STATUS[i*DW +: DW] = 32'hC0DE_0000 | i;
    end
    HW_STATUS[3*DW +: DW] = 32'h5A5A_5A5A;
  end

  function automatic int idx_of(input logic [AW-1:0] addr);
    return int'(addr[5:2]);
  endfunction

  function automatic logic addr_bad(input logic [AW-1:0] addr);
    return (addr[1:0] != 2'b00) || (idx_of(addr) >= NREG);
  endfunction

  // Pushes write expectations and applies the write to the model.
  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb);
    int idx;
    idx = idx_of(addr);
    if (addr_bad(addr) || RO[idx] || strb == 4'h0) begin
      exp_b.push_back(SLVERR);
      exp_pulse.push_back('0);
    end else begin
      exp_b.push_back(OKAY);
      exp_pulse.push_back(NREG'(1) << idx);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic model_read(input logic [AW-1:0] addr);
    rexp_t e;
    if (addr_bad(addr)) begin
      e.data = '0;
      e.resp = SLVERR;
    end else if (RO[idx_of(addr)]) begin
      e.data = HW_STATUS[idx_of(addr)*DW +: DW];
      e.resp = OKAY;
    end else begin
      e.data = model_regs[idx_of(addr)];
      e.resp = OKAY;
    end
    exp_r.push_back(e);
  endtask

  task automatic send_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb);
    logic aw_done, w_done, aw_hs, w_hs;
    S_AWADDR = addr; S_AWVALID = 1'b1;
    S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = S_AWVALID && S_AWREADY;
      w_hs = S_WVALID && S_WREADY;
      @(negedge ACLK);
      if (aw_hs) begin S_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin S_WVALID = 1'b0; w_done = 1'b1; end
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    n_compared++;
    if (!(aw_done && w_done)) begin
      n_mismatched++;
      $display("[TB] FAIL aw_w_accept: got aw=%0b w=%0b required 1 1", aw_done, w_done);
    end
  endtask

  task automatic expect_b(input int hold, input int exp_wait);
    logic [1:0] eresp;
    logic [NREG-1:0] epulse;
    int waited;
    eresp = exp_b.pop_front();
    epulse = exp_pulse.pop_front();
    waited = 0;
    while (!S_BVALID && waited < 20) begin
      @(negedge ACLK);
      waited++;
    end
    n_compared++;
    if (S_BVALID !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bvalid_timeout: got %b required 1", S_BVALID);
      return;
    end
    n_compared++;
    if (waited != exp_wait) begin
      n_mismatched++;
      $display("[TB] FAIL b_latency: got %0d required %0d", waited, exp_wait);
    end
    n_compared++;
    if (S_BRESP !== eresp) begin
      n_mismatched++;
      $display("[TB] FAIL bresp: got %b required %b", S_BRESP, eresp);
    end
    n_compared++;
    if (WR_PULSE !== epulse) begin
      n_mismatched++;
      $display("[TB] FAIL wr_pulse: got %h required %h", WR_PULSE, epulse);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      n_compared++;
      if (S_BVALID !== 1'b1 || S_BRESP !== eresp || WR_PULSE !== '0) begin
        n_mismatched++;
        $display("[TB] FAIL b_stall: got v=%b r=%b p=%h required v=1 r=%b p=0",
                 S_BVALID, S_BRESP, WR_PULSE, eresp);
      end
    end
    S_BREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0;
    n_compared++;
    if (S_BVALID !== 1'b0 || WR_PULSE !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL b_release: got v=%b p=%h required v=0 p=0", S_BVALID, WR_PULSE);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int hold);
    model_write(addr, data, strb);
    send_aw_w(addr, data, strb);
    expect_b(hold, 1);
  endtask

  task automatic send_ar(input logic [AW-1:0] addr);
    logic done, hs;
    S_ARADDR = addr; S_ARVALID = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = S_ARVALID && S_ARREADY;
      @(negedge ACLK);
      if (hs) begin S_ARVALID = 1'b0; done = 1'b1; end
    end
    S_ARVALID = 1'b0;
    n_compared++;
    if (!done) begin
      n_mismatched++;
      $display("[TB] FAIL ar_accept: got 0 required 1");
    end
  endtask

  task automatic expect_r(input int hold);
    rexp_t e;
    int waited;
    e = exp_r.pop_front();
    waited = 0;
    while (!S_RVALID && waited < 20) begin
      @(negedge ACLK);
      waited++;
    end
    n_compared++;
    if (S_RVALID !== 1'b1 || waited != 0) begin
      n_mismatched++;
      $display("[TB] FAIL rvalid_latency: got v=%b wait=%0d required v=1 wait=0", S_RVALID, waited);
      if (S_RVALID !== 1'b1) return;
    end
    n_compared++;
    if (S_RDATA !== e.data || S_RRESP !== e.resp) begin
      n_mismatched++;
      $display("[TB] FAIL rdata: got %h/%b required %h/%b", S_RDATA, S_RRESP, e.data, e.resp);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      n_compared++;
      if (S_RVALID !== 1'b1 || S_RDATA !== e.data || S_RRESP !== e.resp) begin
        n_mismatched++;
        $display("[TB] FAIL r_stall: got v=%b %h/%b required v=1 %h/%b",
                 S_RVALID, S_RDATA, S_RRESP, e.data, e.resp);
      end
    end
    S_RREADY = 1'b1;
    @(negedge ACLK);
    S_RREADY = 1'b0;
    n_compared++;
    if (S_RVALID !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL r_release: got %b required 0", S_RVALID);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    model_read(addr);
    send_ar(addr);
    expect_r(hold);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    n_compared++;
    if (S_BVALID !== 1'b0 || S_RVALID !== 1'b0 || S_RDATA !== '0 || WR_PULSE !== '0 ||
        S_BRESP !== OKAY || S_RRESP !== OKAY) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got bv=%b rv=%b rd=%h p=%h br=%b rr=%b required zeros",
               S_BVALID, S_RVALID, S_RDATA, WR_PULSE, S_BRESP, S_RRESP);
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_compared++;
    if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b1 || S_ARREADY !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ready: got aw=%b w=%b ar=%b required 1 1 1",
               S_AWREADY, S_WREADY, S_ARREADY);
    end
    n_compared++;
    if (REG_OUT !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_regout: got %h required 0", REG_OUT);
    end
  endtask

  task automatic test_basic();
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(32'h04, 0);
    n_compared++;
    if (REG_OUT[1*DW +: DW] !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("[TB] FAIL regout1: got %h required deadbeef", REG_OUT[1*DW +: DW]);
    end
  endtask

  task automatic test_w_before_aw();
    model_write(32'h08, 32'h1234_5678, 4'hF);
    S_WDATA = 32'h1234_5678; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(negedge ACLK);
    S_WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      n_compared++;
      if (S_BVALID !== 1'b0 || S_WREADY !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL w_only_wait: got bv=%b wr=%b required 0 0", S_BVALID, S_WREADY);
      end
    end
    S_AWADDR = 32'h08; S_AWVALID = 1'b1;
    n_compared++;
    if (S_AWREADY !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL awready_late: got %b required 1", S_AWREADY);
    end
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    expect_b(0, 1);
    do_read(32'h08, 0);
  endtask

  task automatic test_strobe();
    do_write(32'h10, 32'h1122_3344, 4'hF, 0);
    do_write(32'h10, 32'h0000_AA00, 4'h2, 0);
    do_read(32'h10, 0);
    n_compared++;
    if (REG_OUT[4*DW +: DW] !== 32'h1122_AA44) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_merge: got %h required 1122aa44", REG_OUT[4*DW +: DW]);
    end
  endtask

  task automatic test_read_only();
    do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 0);
    do_read(32'h0C, 0);
    n_compared++;
    if (REG_OUT[3*DW +: DW] !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL ro_regout: got %h required 0", REG_OUT[3*DW +: DW]);
    end
  endtask

  task automatic test_errors();
    do_write(32'h20, 32'h0F0F_0F0F, 4'hF, 0);
    do_write(32'h20, 32'hFFFF_FFFF, 4'h0, 0);
    do_write(32'h06, 32'h0BAD_0BAD, 4'hF, 0);
    do_write(32'h30, 32'h0BAD_0BAD, 4'hF, 0);
    do_read(32'h20, 0);
    do_read(32'h04, 0);
    do_read(32'h02, 0);
    do_read(32'h30, 0);
    do_read(32'h1000_0024, 0);
  endtask

  task automatic test_stall();
    do_write(32'h1C, 32'hA5A5_0001, 4'hF, 5);
    do_read(32'h1C, 5);
    do_write(32'h0C, 32'h1, 4'hF, 5);
  endtask

  task automatic test_back_to_back();
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, 0);
    model_read(32'h14);
    model_write(32'h14, 32'hCAFE_F00D, 4'hF);
    S_AWADDR = 32'h14; S_AWVALID = 1'b1;
    S_WDATA = 32'hCAFE_F00D; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(negedge ACLK);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    S_ARADDR = 32'h14; S_ARVALID = 1'b1;
    @(negedge ACLK);
    S_ARVALID = 1'b0;
    expect_b(0, 0);
    expect_r(0);
    do_read(32'h14, 0);
  endtask

  task automatic test_reset_mid();
    int waited;
    send_aw_w(32'h18, 32'h7777_8888, 4'hF);
    waited = 0;
    while (!S_BVALID && waited < 20) begin
      @(negedge ACLK);
      waited++;
    end
    n_compared++;
    if (S_BVALID !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_bvalid: got %b required 1", S_BVALID);
    end
    #2 ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    n_compared++;
    if (S_BVALID !== 1'b0 || REG_OUT !== '0 || WR_PULSE !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: got bv=%b regout=%h p=%h required all 0",
               S_BVALID, REG_OUT, WR_PULSE);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    S_AWADDR = 32'h04; S_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    S_WDATA = 32'h4444_5555; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(negedge ACLK);
    S_WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      n_compared++;
      if (S_BVALID !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL abandoned_aw: got bvalid %b required 0", S_BVALID);
      end
    end
    model_write(32'h04, 32'h4444_5555, 4'hF);
    S_AWADDR = 32'h04; S_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    expect_b(0, 1);
    do_read(32'h04, 0);
    do_read(32'h18, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge ACLK);
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobe();
    test_read_only();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
